// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memsize encodings, FSM states
// and the memsize-to-byte-count helper.
package lsu_pkg;

  // funct3-style access size encodings
  localparam logic [2:0] MS_B  = 3'b000;
  localparam logic [2:0] MS_H  = 3'b001;
  localparam logic [2:0] MS_W  = 3'b010;
  localparam logic [2:0] MS_BU = 3'b100;
  localparam logic [2:0] MS_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_FIN   = 2'd3
  } lsu_state_e;

  // Bytes touched by an access; 0 marks an illegal encoding.
  function automatic logic [2:0] size_bytes(input logic [2:0] ms);
    logic [2:0] n;
    case (ms)
      MS_B, MS_BU: n = 3'd1;
      MS_H, MS_HU: n = 3'd2;
      MS_W:        n = 3'd4;
      default:     n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane shifter/extender: builds the 8-bit strobe mask and the
// 64-bit shifted write data spanning two beats, and extracts/extends load
// data from the captured {beat1, beat0} buffer.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  memsize,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [63:0] rbuf,
  output logic [7:0]  strb,
  output logic [63:0] wlanes,
  output logic [31:0] rdata,
  output logic        split
);

  logic [2:0]  nbytes;
  logic [3:0]  mask;
  logic [31:0] rshift;

  // Lane placement for stores and byte extraction/extension for loads
  always_comb begin
    nbytes = size_bytes(memsize);
    case (nbytes)
      3'd1:    mask = 4'b0001;
      3'd2:    mask = 4'b0011;
      3'd4:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    strb   = {4'b0000, mask} << offset;
    wlanes = {32'h0, wdata} << {offset, 3'b000};
    // An access crosses the word boundary when offset + size exceeds 4
    split  = ({1'b0, offset} + nbytes) > 3'd4;
    rshift = 32'(rbuf >> {offset, 3'b000});
    case (memsize)
      MS_B:    rdata = {{24{rshift[7]}}, rshift[7:0]};
      MS_BU:   rdata = {24'h0, rshift[7:0]};
      MS_H:    rdata = {{16{rshift[15]}}, rshift[15:0]};
      MS_HU:   rdata = {16'h0, rshift[15:0]};
      MS_W:    rdata = rshift;
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit. Samples one request in IDLE, issues one or two
// word beats on a req/ack bus, and pulses done (and err for an illegal size)
// in FIN.
//
// Bus handshake: bus_req is raised at the start of a beat and held until the
// first rising edge where bus_ack=1; that edge completes the beat. While
// bus_req is high and ack has not been seen, bus_addr/bus_we/bus_wstrb/
// bus_wdata are stable. For reads bus_rdata is taken on the ack edge.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              memtoreg,
  input  logic              memwrite,
  input  logic [2:0]        memsize,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-3:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output lsu_state_e        dbg_state
);

  lsu_state_e        state, state_next;

  // Request captured in IDLE; inputs are ignored until the next IDLE
  logic              op_we;
  logic [2:0]        op_size;
  logic [1:0]        op_off;
  logic [ADDR_W-3:0] op_word;
  logic [31:0]       op_wdata;
  logic              op_err;

  logic [31:0]       beat0_q;
  logic [31:0]       rdata_q;
  logic              bus_req_q;

  logic              start;
  logic              legal;
  logic              load_op;
  logic              capture_lo;
  logic              finish;

  logic [7:0]        al_strb;
  logic [63:0]       al_wlanes;
  logic [31:0]       al_rdata;
  logic              al_split;
  logic [63:0]       rbuf;
  logic              in_beat1;
  logic              wr_beat;

  assign start = req_valid & (memtoreg | memwrite);
  assign legal = (size_bytes(memsize) != 3'd0);

  // Next-state and per-cycle strobes for the access sequencer
  always_comb begin
    state_next = state;
    load_op    = 1'b0;
    capture_lo = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_op    = 1'b1;
          state_next = legal ? ST_BEAT0 : ST_FIN;
        end
      end
      ST_BEAT0: begin
        if (bus_ack) begin
          if (al_split) begin
            capture_lo = 1'b1;
            state_next = ST_BEAT1;
          end else begin
            finish     = 1'b1;
            state_next = ST_FIN;
          end
        end
      end
      ST_BEAT1: begin
        if (bus_ack) begin
          finish     = 1'b1;
          state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register and bus request; reset abandons any in-flight beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bus_req_q <= 1'b0;
    end else begin
      state     <= state_next;
      bus_req_q <= (state_next == ST_BEAT0) || (state_next == ST_BEAT1);
    end
  end

  // Request capture, low-beat buffer and final load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_we    <= 1'b0;
      op_size  <= 3'b000;
      op_off   <= 2'b00;
      op_word  <= '0;
      op_wdata <= 32'h0;
      op_err   <= 1'b0;
      beat0_q  <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      if (load_op) begin
        op_we    <= memwrite;
        op_size  <= memsize;
        op_off   <= addr[1:0];
        op_word  <= addr[ADDR_W-1:2];
        op_wdata <= wdata;
        op_err   <= ~legal;
        rdata_q  <= 32'h0;
      end
      if (capture_lo) begin
        beat0_q <= bus_rdata;
      end
      if (finish) begin
        rdata_q <= op_we ? 32'h0 : al_rdata;
      end
    end
  end

  // The second word of a split load arrives with ack in BEAT1; a single-beat
  // load sees its only word in BEAT0
  assign in_beat1 = (state == ST_BEAT1);
  assign rbuf     = in_beat1 ? {bus_rdata, beat0_q} : {32'h0, bus_rdata};

  lsu_align u_align (
    .memsize (op_size),
    .offset  (op_off),
    .wdata   (op_wdata),
    .rbuf    (rbuf),
    .strb    (al_strb),
    .wlanes  (al_wlanes),
    .rdata   (al_rdata),
    .split   (al_split)
  );

  assign wr_beat   = bus_req_q & op_we;
  assign bus_req   = bus_req_q;
  assign bus_we    = wr_beat;
  assign bus_addr  = in_beat1 ? (op_word + {{(ADDR_W-3){1'b0}}, 1'b1}) : op_word;
  assign bus_wstrb = wr_beat ? (in_beat1 ? al_strb[7:4] : al_strb[3:0]) : 4'b0000;
  assign bus_wdata = wr_beat ? (in_beat1 ? al_wlanes[63:32] : al_wlanes[31:0]) : 32'h0;

  assign stall     = ((state == ST_IDLE) && start) ||
                     (state == ST_BEAT0) || (state == ST_BEAT1);
  assign done      = (state == ST_FIN);
  assign err       = (state == ST_FIN) && op_err;
  assign rdata     = rdata_q;
  assign dbg_state = state;

endmodule
